// File: rtl/cla_addsub_pipe.sv
// Two-stage carry-lookahead adder/subtractor with valid/ready handshake.
// Define CLA_ADDSUB_SATURATE_EN to clamp signed overflow instead of wrapping.
module cla_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [3:0]       flags
);

  localparam int NG = WIDTH / GROUP;

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gc;
  } s1_t;

  s1_t              s1_d;
  s1_t              s1_q;
  logic             s1_valid;
  logic             s2_valid;
  logic             s2_en;
  logic [WIDTH-1:0] sum_d;
  logic [3:0]       flags_d;

  assign s2_en     = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign out_valid = s2_valid;

  always_comb begin : s1_comb
    logic [WIDTH-1:0] bb;
    logic             c;
    logic             pk;
    logic             gk;
    s1_d = '0;
    bb   = op[0] ? ~b : b;
    c    = op[1] ? cin : op[0];
    s1_d.p = a ^ bb;
    s1_d.g = a & bb;
    for (int k = 0; k < NG; k++) begin
      pk = 1'b1;
      gk = 1'b0;
      for (int i = 0; i < GROUP; i++) begin
        gk = s1_d.g[k*GROUP+i] | (s1_d.p[k*GROUP+i] & gk);
        pk = pk & s1_d.p[k*GROUP+i];
      end
      s1_d.gc[k] = c;
      s1_d.gp[k] = pk;
      s1_d.gg[k] = gk;
      c = gk | (pk & c);
    end
  end

  // Group carry-ins are re-derived from the registered P/G so that
  // the group-level lookahead and the carry out share one path.
  always_comb begin : s2_comb
    logic [NG:0]      gci;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             cm;
    logic             v;
    int               j;
    s   = '0;
    cm  = 1'b0;
    gci = '0;
    gci[0] = s1_q.gc[0];
    for (int k = 0; k < NG; k++) begin
      gci[k+1] = s1_q.gg[k] | (s1_q.gp[k] & s1_q.gc[k]);
    end
    for (int k = 0; k < NG; k++) begin
      c = gci[k];
      for (int i = 0; i < GROUP; i++) begin
        j    = k * GROUP + i;
        s[j] = s1_q.p[j] ^ c;
        if (j == WIDTH - 1) cm = c;
        c = s1_q.g[j] | (s1_q.p[j] & c);
      end
    end
    v = cm ^ gci[NG];
`ifdef CLA_ADDSUB_SATURATE_EN
    if (v) begin
      s = s[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                     : {1'b1, {(WIDTH-1){1'b0}}};
    end
`else
`endif
    sum_d   = s;
    flags_d = {s[WIDTH-1], s == '0, v, gci[NG]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      flags    <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum   <= sum_d;
        flags <= flags_d;
      end
    end
  end

endmodule

// File: doc/cla_addsub_pipe.md
CLA_ADDSUB_PIPE -- requirements
Module: cla_addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal values are multiples of 4 from 8 to 64.
REQ-002 SHALL have parameter GROUP, default 4, carry-lookahead group size in bits; WIDTH SHALL be a multiple of GROUP.
REQ-003 SHALL have port clk  input  1  single clock; all registers update on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts the beat this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port op  input  2  operation: 00 = A+B, 01 = A-B, 10 = A+B+cin, 11 = A-B-~cin (borrow chain).
REQ-010 SHALL have port cin  input  1  carry/not-borrow in; used only for op 10 and op 11.
REQ-011 SHALL have port out_valid  output  1  result beat present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port flags  output  4  {n, z, v, c}: negative, zero, signed overflow, carry out.

Function
REQ-015 SHALL accept a beat when in_valid && in_ready, and SHALL emit a beat when out_valid && out_ready.
REQ-016 SHALL compute B' = ~B for op[0]=1, else B; carry-in = op[0] for op 0x, cin for op 1x; result = A + B' + carry-in, modulo 2^WIDTH.
REQ-017 SHALL use two pipeline stages: stage 1 registers per-group P/G and group carries; stage 2 registers sum and flags; the latency from accept to out_valid SHALL be 2 cycles with no stall.
REQ-018 SHALL set c to the carry out of bit WIDTH-1 of the addition; for subtraction, c=1 means no borrow.
REQ-019 SHALL set v = carry into MSB XOR carry out of MSB; n = sum[WIDTH-1]; z = (sum == 0).
REQ-020 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready; this lets the pipe fill when empty and advance when the output drains.
REQ-021 SHALL hold sum, flags and out_valid stable while out_valid && !out_ready, and stage 1 SHALL hold while stage 2 is blocked.
REQ-022 SHALL sustain one result per cycle with out_ready held at 1, and SHALL produce no bubbles or duplicates.
REQ-023 SHALL, on a simultaneous accept and emit in a full pipe, shift both stages in the same cycle.
REQ-024 SHALL ignore a, b, op and cin when in_valid=0; a beat with in_valid=0 SHALL NOT alter stage contents.
REQ-025 SHALL produce wrap-around results without error: 0xFFFF+1 gives 0x0000 with c=1 and z=1 (WIDTH=16).

Reset
REQ-026 SHALL, when rst_n=0, clear both stage valid bits, sum and flags to 0 immediately, without waiting for clk.
REQ-027 SHALL, on reset mid-operation, discard all in-flight beats; no partial result SHALL appear after release.
REQ-028 SHALL drive in_ready=1 during reset and out_valid=0 from reset assertion until the first accepted beat completes.

Configuration
REQ-029 SHALL support macro CLA_ADDSUB_SATURATE_EN; when defined, if v=1 the sum SHALL clamp to the signed maximum (0x7FFF for WIDTH=16) when the true result is positive, or to the signed minimum (0x8000) when negative, with flags v=1, n and z recomputed from the clamped value, and c unchanged.
REQ-030 SHALL, without CLA_ADDSUB_SATURATE_EN, output the wrapped sum; v SHALL still report overflow.

Verification
REQ-031 Bench SHALL check: WIDTH=16, op=00, a=0x1234, b=0x0FCD -> sum 0x2201, flags n0 z0 v0 c0, out_valid exactly 2 cycles after accept.
REQ-032 Bench SHALL check: op=01, a=0x0005, b=0x0007 -> sum 0xFFFE, n1 c0 v0; and a=0x8000, b=0x0001 -> sum 0x7FFF v1 (wrap build) or 0x8000 v1 (CLA_ADDSUB_SATURATE_EN).
REQ-033 Bench SHALL check: 32-bit add done as two op=00/op=10 beats, low 0xFFFF+0x0001 then high 0x0000+0x0000 with cin=c -> 0x0000 then 0x0001.
REQ-034 Bench SHALL check: back-to-back 8 beats, out_ready low for 3 cycles mid-stream -> in_ready drops once both stages are full, all 8 results come out in order with none lost, and outputs stay stable while stalled.
REQ-035 Bench SHALL check: rst_n pulsed low between clk edges with 2 beats in flight -> out_valid, sum and flags go to 0 at once, and no result appears after release.
